// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: first-word-fall-through FIFO controller that drives a dual-port
// BRAM. The BRAM has a 1-cycle registered read. A one-entry holding stage keeps
// the head word stable while the consumer stalls.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  bram_readEnable,
  output logic [ADDR_WIDTH-1:0] bram_readAddress,
  input  logic [DATA_WIDTH-1:0] bram_readData,
  output logic                  bram_writeEnable,
  output logic [ADDR_WIDTH-1:0] bram_writeAddress,
  output logic [DATA_WIDTH-1:0] bram_writeData
);

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, mem_count;
  logic                  rd_inflight, hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  full, empty, push, issue;

  // The wrap bit tells full from empty when the low address bits match
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign mem_count = wr_ptr - rd_ptr;

  // Reset is folded in so that no write is accepted while reset is held
  assign push_ready = reset & ~full;
  assign push       = push_valid & push_ready;

  assign pop_valid  = rd_inflight | hold_valid;
  assign pop_data   = hold_valid ? hold_data : bram_readData;
  // Issue a read only when the output slot is empty or is emptying this cycle
  assign issue      = ~empty & (~pop_valid | pop_ready);
  assign count      = mem_count + {{ADDR_WIDTH{1'b0}}, pop_valid};

  assign bram_writeEnable  = push;
  assign bram_writeAddress = wr_ptr[ADDR_WIDTH-1:0];
  assign bram_writeData    = push_data;
  assign bram_readEnable   = issue;
  assign bram_readAddress  = rd_ptr[ADDR_WIDTH-1:0];

  // Pointer advance and read-in-flight tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      rd_inflight <= issue;
    end
  end

  // Capture returning BRAM data when the consumer stalls, release it on pop.
  // A read is never issued while the hold entry stalls, so the two cannot collide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (rd_inflight && !pop_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= bram_readData;
    end else if (hold_valid && pop_ready) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl. It attaches a BRAM model to the DUT and keeps a
// queue-based reference. A word accepted in cycle t may head the output from
// cycle t+2. The bench adds directed scenarios with literal expectations.
module tb_bram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push_valid, push_ready, pop_valid, pop_ready;
  logic [DW-1:0] push_data, pop_data;
  logic [AW:0]   count;
  logic          bram_readEnable, bram_writeEnable;
  logic [AW-1:0] bram_readAddress, bram_writeAddress;
  logic [DW-1:0] bram_readData, bram_writeData;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .bram_readEnable(bram_readEnable), .bram_readAddress(bram_readAddress),
    .bram_readData(bram_readData),
    .bram_writeEnable(bram_writeEnable), .bram_writeAddress(bram_writeAddress),
    .bram_writeData(bram_writeData)
  );

  always #5 clock = ~clock;

  // BRAM: registered read, zero when idle, write-to-read bypass on same address
  logic [DW-1:0] mem [0:DEPTH-1];
  initial bram_readData = '0;
  always @(posedge clock) begin
    if (bram_readEnable)
      bram_readData <= (bram_writeEnable && bram_writeAddress == bram_readAddress)
                       ? bram_writeData : mem[bram_readAddress];
    else
      bram_readData <= '0;
    if (bram_writeEnable) mem[bram_writeAddress] <= bram_writeData;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: queue of (word, accept cycle)
  typedef struct { logic [DW-1:0] d; int stamp; } ent_t;
  ent_t q[$];
  int   cyc = 0;

  function automatic logic m_pv();
    return (q.size() > 0) && (q[0].stamp <= cyc - 2);
  endfunction

  function automatic logic m_pr();
    return (q.size() - int'(m_pv())) != DEPTH;
  endfunction

  // Reference update on each rising edge
  always @(posedge clock) begin
    logic pv, pr;
    pv = m_pv();
    pr = m_pr();
    if (!reset) q.delete();
    else begin
      if (pv && pop_ready) void'(q.pop_front());
      if (push_valid && pr) q.push_back('{push_data, cyc});
    end
    cyc++;
  end

  // Compare process, on the falling edge
  logic [DW-1:0] got[$];
  int            maxc = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_push_ready", push_ready, 0);
      chk("rst_pop_valid", pop_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_read_en", bram_readEnable, 0);
      chk("rst_write_en", bram_writeEnable, 0);
      prev_hold = 1'b0;
    end else begin
      chk("pop_valid", pop_valid, m_pv());
      chk("count", count, q.size());
      chk("push_ready", push_ready, m_pr());
      chk("write_en", bram_writeEnable, push_valid && m_pr());
      if (m_pv()) chk("pop_data", pop_data, q[0].d);
      chk("hold_inflight_exclusive", dut.rd_inflight & dut.hold_valid, 0);
      if (prev_hold && pop_valid) chk("pop_data_stable", pop_data, prev_data);
      prev_hold = pop_valid && !pop_ready;
      prev_data = pop_data;
      if (pop_valid && pop_ready) got.push_back(pop_data);
      if (int'(count) > maxc) maxc = int'(count);
    end
  end

  task automatic drive(input logic pv, input logic [DW-1:0] d, input logic pr);
    push_valid = pv;
    push_data  = d;
    pop_ready  = pr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxxxxxx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ncyc;
    logic acc;
    drive(0, '0, 0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Latency: push in cycle 0, read issue in cycle 1, word visible in cycle 2
    drive(1, 32'hA5A50001, 1); tick();
    drive(0, '0, 1); #2;
    chk("lat_c1_read_en", bram_readEnable, 1);
    chk("lat_c1_pop_valid", pop_valid, 0);
    tick(); #2;
    chk("lat_c2_pop_valid", pop_valid, 1);
    chk("lat_c2_pop_data", pop_data, 32'hA5A50001);
    tick(); #2;
    chk("lat_c3_count", count, 0);
    chk("lat_c3_pop_valid", pop_valid, 0);
    tick();

    // Fill: only 5 of 6 words fit (4 in BRAM + 1 in output stage)
    got.delete();
    for (int i = 0; i < 6; i++) begin drive(1, 32'h10 + i, 0); tick(); end
    drive(0, '0, 0); #2;
    chk("fill_count", count, 5);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_pop_valid", pop_valid, 1);
    chk("fill_head", pop_data, 32'h10);
    tick(); tick(); #2;
    chk("fill_head_stable", pop_data, 32'h10);
    drive(0, '0, 1);
    repeat (8) tick();
    #2;
    chk("drain_count", count, 0);
    chk("drain_pop_valid", pop_valid, 0);
    chk("drain_n", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("drain_order", got_at(i), 32'h10 + i);

    // Streaming: one push and one pop per cycle
    got.delete(); maxc = 0;
    for (int i = 0; i < 100; i++) begin drive(1, i, 1); tick(); end
    drive(0, '0, 1);
    repeat (4) tick();
    chk("stream_n", got.size(), 100);
    for (int i = 0; i < 100; i++) chk("stream_order", got_at(i), i);
    chk("stream_max_count_le2", maxc <= 2, 1);

    // Backpressure: random consumer stalls
    got.delete(); n = 0; ncyc = 0;
    while (n < 64 && ncyc < 2000) begin
      drive(1, 32'h1000 + n, 1'($urandom_range(0, 1)));
      #2 acc = push_ready;
      tick();
      if (acc) n++;
      ncyc++;
    end
    chk("bp_all_accepted", n, 64);
    drive(0, '0, 1);
    repeat (8) tick();
    chk("bp_n", got.size(), 64);
    for (int i = 0; i < 64; i++) chk("bp_order", got_at(i), 32'h1000 + i);

    // Wrap: three fill/drain rounds of 4 words across pointer roll-over
    got.delete();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin drive(1, 32'h200 + r * 4 + k, 0); tick(); end
      drive(0, '0, 0); tick(); tick(); #2;
      chk("wrap_count", count, 4);
      chk("wrap_push_ready", push_ready, 1);
      drive(0, '0, 1);
      repeat (6) tick();
      #2;
      chk("wrap_empty_count", count, 0);
      chk("wrap_empty_pop_valid", pop_valid, 0);
      drive(0, '0, 0); tick();
    end
    chk("wrap_n", got.size(), 12);
    for (int i = 0; i < 12; i++) chk("wrap_order", got_at(i), 32'h200 + i);

    // Reset mid-operation: words stored, a read in flight
    for (int i = 0; i < 3; i++) begin drive(1, 32'h300 + i, 0); tick(); end
    drive(0, '0, 0); tick();
    drive(0, '0, 1); tick();
    chk("pre_reset_pop_valid", pop_valid, 1);
    drive(0, '0, 0);
    reset = 1'b0;
    #1;
    chk("midrst_pop_valid", pop_valid, 0);
    chk("midrst_count", count, 0);
    tick();
    reset = 1'b1;
    got.delete();
    drive(1, 32'hDEAD0000, 1); tick();
    drive(0, '0, 1);
    repeat (6) tick();
    chk("post_rst_n", got.size(), 1);
    chk("post_rst_word", got_at(0), 32'hDEAD0000);
    chk("post_rst_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
